mcu_bus_arbiter: RTL

Sequences the MCU asynchronous parallel bus (`mc_ce`/`mc_oe`/`mc_we`, 6-bit address, 16-bit data) into the single-port FPGA register file. It also shares that register file with the internal protocol engine, with the MCU given priority. It sits between the top-level MCU pins and the register file, and owns the `irq0`/`irq1` mailbox interrupts back to the MCU.

---
 rtl/mcu_bus_pkg.sv | 24 ++
 rtl/mcu_bus_arbiter_sync.sv | 39 +++
 rtl/mcu_bus_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mcu_bus_pkg.sv
// mcu_bus_pkg
// Shared definitions for the MCU bus arbiter: bus widths, the two mailbox
// register addresses and the arbiter FSM state encoding.
package mcu_bus_pkg;

  localparam int MC_DATA_WIDTH = 16;
  localparam int MC_ADD_WIDTH  = 6;

  // Mailbox registers: an engine write raises the matching irq, an MCU read
  // of the same register drops it.
  localparam logic [MC_ADD_WIDTH-1:0] MBX0_ADD = 6'h3E;
  localparam logic [MC_ADD_WIDTH-1:0] MBX1_ADD = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MC_RD,
    ST_MC_RD_CAP,
    ST_MC_WR,
    ST_MC_HOLD,
    ST_ENG,
    ST_ENG_ACK
  } arb_state_t;

endpackage

// File: rtl/mcu_bus_arbiter_sync.sv
// mcu_strobe_sync
// Multi-flop synchronizer for the three active-low MCU strobes. Every stage
// resets to 1 so the strobes read as inactive while and after reset.
// Ports:
//   clock     system clock
//   reset     asynchronous active-low reset
//   strobe_in {mc_ce, mc_oe, mc_we} straight from the pins
//   strobe_s  synchronized {ce_s, oe_s, we_s}
module mcu_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] strobe_in,
  output logic [2:0] strobe_s
);

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [SYNC_STAGES-1:0][2:0] sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = strobe_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign strobe_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_bus_arbiter.sv
// mcu_bus_arbiter
// Sequences the asynchronous MCU parallel bus into the single-port register
// file and shares that register file with the protocol engine (MCU first).
// Also owns the two mailbox interrupts back to the MCU.
// Ports:
//   clock, reset            system clock, async active-low reset
//   mc_ce/mc_oe/mc_we       active-low MCU strobes (asynchronous)
//   mc_add, mc_data_in      MCU address and write data
//   mc_data_out, mc_data_oe registered read data, pin output enable
//   eng_req/eng_we/eng_add/eng_wdata  engine request side
//   eng_ack, eng_rdata      engine completion pulse and read data
//   rf_en/rf_we/rf_add/rf_wdata/rf_rdata  register file port (1-cycle read)
//   irq0, irq1              mailbox interrupts (level, active-high)
module mcu_bus_arbiter #(
  parameter int MC_DATA_WIDTH = mcu_bus_pkg::MC_DATA_WIDTH,
  parameter int MC_ADD_WIDTH  = mcu_bus_pkg::MC_ADD_WIDTH,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mc_ce,
  input  logic                     mc_oe,
  input  logic                     mc_we,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  input  logic [MC_DATA_WIDTH-1:0] mc_data_in,
  output logic [MC_DATA_WIDTH-1:0] mc_data_out,
  output logic                     mc_data_oe,
  input  logic                     eng_req,
  input  logic                     eng_we,
  input  logic [MC_ADD_WIDTH-1:0]  eng_add,
  input  logic [MC_DATA_WIDTH-1:0] eng_wdata,
  output logic                     eng_ack,
  output logic [MC_DATA_WIDTH-1:0] eng_rdata,
  output logic                     rf_en,
  output logic                     rf_we,
  output logic [MC_ADD_WIDTH-1:0]  rf_add,
  output logic [MC_DATA_WIDTH-1:0] rf_wdata,
  input  logic [MC_DATA_WIDTH-1:0] rf_rdata,
  output logic                     irq0,
  output logic                     irq1
);
  import mcu_bus_pkg::*;

  localparam logic [MC_ADD_WIDTH-1:0] MBX0 = MC_ADD_WIDTH'(MBX0_ADD);
  localparam logic [MC_ADD_WIDTH-1:0] MBX1 = MC_ADD_WIDTH'(MBX1_ADD);

  logic [2:0] strobe_s;
  logic       ce_s;
  logic       oe_s;
  logic       we_s;

  arb_state_t                 state_q, state_d;
  logic [MC_DATA_WIDTH-1:0]   mc_data_out_q, mc_data_out_d;
  logic                       rf_en_q, rf_en_d;
  logic                       rf_we_q, rf_we_d;
  logic [MC_ADD_WIDTH-1:0]    rf_add_q, rf_add_d;
  logic [MC_DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
  logic                       eng_ack_q, eng_ack_d;
  logic                       irq0_q, irq0_d;
  logic                       irq1_q, irq1_d;

  mcu_strobe_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_strobe_sync (
    .clock     (clock),
    .reset     (reset),
    .strobe_in ({mc_ce, mc_oe, mc_we}),
    .strobe_s  (strobe_s)
  );

  assign {ce_s, oe_s, we_s} = strobe_s;

  // Straight from the pins so the data bus turns around without waiting for
  // the synchronizer; forced off while reset is held.
  assign mc_data_oe = reset && !mc_ce && !mc_oe && mc_we;

  always_comb begin
    state_d       = state_q;
    mc_data_out_d = mc_data_out_q;
    rf_en_d       = 1'b0;
    rf_we_d       = 1'b0;
    rf_add_d      = rf_add_q;
    rf_wdata_d    = rf_wdata_q;
    eng_ack_d     = 1'b0;
    irq0_d        = irq0_q;
    irq1_d        = irq1_q;

    unique case (state_q)
      ST_IDLE: begin
        // MCU strobes are checked first so they win a same-cycle tie.
        if (!ce_s && !we_s) begin
          state_d    = ST_MC_WR;
          rf_en_d    = 1'b1;
          rf_we_d    = 1'b1;
          rf_add_d   = mc_add;
          rf_wdata_d = mc_data_in;
        end else if (!ce_s && !oe_s) begin
          state_d  = ST_MC_RD;
          rf_en_d  = 1'b1;
          rf_add_d = mc_add;
        end else if (ce_s && eng_req) begin
          state_d    = ST_ENG;
          rf_en_d    = 1'b1;
          rf_we_d    = eng_we;
          rf_add_d   = eng_add;
          rf_wdata_d = eng_wdata;
        end
      end
      ST_MC_RD: begin
        state_d = ST_MC_RD_CAP;
      end
      ST_MC_RD_CAP: begin
        // rf_add_q still holds the read address; the mailbox irq is only
        // dropped once the read has actually delivered its data.
        mc_data_out_d = rf_rdata;
        if (rf_add_q == MBX0) irq0_d = 1'b0;
        if (rf_add_q == MBX1) irq1_d = 1'b0;
        state_d = ST_MC_HOLD;
      end
      ST_MC_WR: begin
        state_d = ST_MC_HOLD;
      end
      ST_MC_HOLD: begin
        // One register access per mc_ce low period: wait for it to rise.
        if (ce_s) state_d = ST_IDLE;
      end
      ST_ENG: begin
        // rf_we_q is the engine's write strobe that is on the bus this cycle.
        eng_ack_d = 1'b1;
        if (rf_we_q && (rf_add_q == MBX0)) irq0_d = 1'b1;
        if (rf_we_q && (rf_add_q == MBX1)) irq1_d = 1'b1;
        state_d = ST_ENG_ACK;
      end
      ST_ENG_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      mc_data_out_q <= '0;
      rf_en_q       <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_add_q      <= '0;
      rf_wdata_q    <= '0;
      eng_ack_q     <= 1'b0;
      irq0_q        <= 1'b0;
      irq1_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mc_data_out_q <= mc_data_out_d;
      rf_en_q       <= rf_en_d;
      rf_we_q       <= rf_we_d;
      rf_add_q      <= rf_add_d;
      rf_wdata_q    <= rf_wdata_d;
      eng_ack_q     <= eng_ack_d;
      irq0_q        <= irq0_d;
      irq1_q        <= irq1_d;
    end
  end

  assign mc_data_out = mc_data_out_q;
  assign rf_en       = rf_en_q;
  assign rf_we       = rf_we_q;
  assign rf_add      = rf_add_q;
  assign rf_wdata    = rf_wdata_q;
  assign eng_ack     = eng_ack_q;
  assign irq0        = irq0_q;
  assign irq1        = irq1_q;

  // The register file answers during the ack cycle, so read data is passed
  // through while eng_ack is high and held at zero otherwise.
  assign eng_rdata = eng_ack_q ? rf_rdata : '0;

endmodule
